// File: rtl/lsu_bus_adapter.sv
// Load/store adapter between the CPU Wishbone-style master port and word-wide memory:
// size decode, lane steering, load extension, misalignment rejection and a bounded wait.
module lsu_bus_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_SHIFT     = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [2:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_err,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [3:0]  o_mem_sel,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_ack,
    input  logic        i_mem_stall
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ERR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               req_we;
    logic [31:0]        req_addr;
    logic [31:0]        req_data;
    logic [2:0]         req_sel;

    logic               illegal_c;
    logic [3:0]         lane_sel_c;
    logic [31:0]        lane_data_c;
    logic [31:0]        shifted_c;
    logic [31:0]        load_data_c;

    // Classify the incoming request against size code and alignment.
    always_comb begin
        illegal_c = 1'b1;
        case (i_wb_sel)
            3'b000:  illegal_c = 1'b0;
            3'b001:  illegal_c = i_wb_addr[0];
            3'b010:  illegal_c = (i_wb_addr[1:0] != 2'b00);
            3'b100:  illegal_c = i_wb_we;
            3'b101:  illegal_c = i_wb_we | i_wb_addr[0];
            default: illegal_c = 1'b1;
        endcase
    end

    // Byte enables and replicated store data for the latched request.
    always_comb begin
        lane_sel_c  = 4'b1111;
        lane_data_c = req_data;
        case (req_sel[1:0])
            2'b00: begin
                lane_sel_c  = 4'b0001 << req_addr[1:0];
                lane_data_c = {4{req_data[7:0]}};
            end
            2'b01: begin
                lane_sel_c  = 4'b0011 << req_addr[1:0];
                lane_data_c = {2{req_data[15:0]}};
            end
            default: begin
                lane_sel_c  = 4'b1111;
                lane_data_c = req_data;
            end
        endcase
    end

    // Right-justify the addressed lane and extend it.
    always_comb begin
        shifted_c   = i_mem_data >> {req_addr[1:0], 3'b000};
        load_data_c = shifted_c;
        case (req_sel)
            3'b000:  load_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b100:  load_data_c = {24'h000000, shifted_c[7:0]};
            3'b001:  load_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b101:  load_data_c = {16'h0000, shifted_c[15:0]};
            default: load_data_c = shifted_c;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_data   <= '0;
            req_sel    <= '0;
            o_wb_data  <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_stall <= 1'b0;
            o_wb_err   <= 1'b0;
            o_mem_stb  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_mem_sel  <= '0;
        end else begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_mem_stb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_wb_stb && !o_wb_stall) begin
                        req_we     <= i_wb_we;
                        req_addr   <= i_wb_addr;
                        req_data   <= i_wb_data;
                        req_sel    <= i_wb_sel;
                        o_wb_stall <= 1'b1;
                        state      <= illegal_c ? S_ERR : S_REQ;
                    end
                end
                S_REQ: begin
                    if (!i_mem_stall) begin
                        o_mem_stb  <= 1'b1;
                        o_mem_we   <= req_we;
                        o_mem_addr <= req_addr >> ADDR_SHIFT;
                        o_mem_sel  <= lane_sel_c;
                        o_mem_data <= lane_data_c;
                        tmo_cnt    <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    // A memory ack coinciding with the timeout still completes successfully.
                    if (i_mem_ack) begin
                        if (!req_we) begin
                            o_wb_data <= load_data_c;
                        end
                        o_wb_ack   <= 1'b1;
                        o_wb_stall <= 1'b0;
                        state      <= S_IDLE;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        o_wb_ack   <= 1'b1;
                        o_wb_err   <= 1'b1;
                        o_wb_stall <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_ERR: begin
                    o_wb_ack   <= 1'b1;
                    o_wb_err   <= 1'b1;
                    o_wb_stall <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Scoreboard bench for lsu_bus_adapter: directed requests push expected responses,
// independent monitors compare whenever the adapter acks or strobes memory.
module tb_lsu_bus_adapter;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [2:0]  i_wb_sel;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic        o_wb_err;
    logic        o_mem_stb;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_sel;
    logic [31:0] i_mem_data;
    logic        i_mem_ack;
    logic        i_mem_stall;

    logic        model_ack;
    logic        stray_ack;
    logic        ack_en;
    logic [31:0] mem_word;

    assign i_mem_ack = model_ack | stray_ack;

    lsu_bus_adapter #(.TIMEOUT_CYCLES(4), .ADDR_SHIFT(2)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_wb_stb    (i_wb_stb),
        .i_wb_we     (i_wb_we),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .i_wb_sel    (i_wb_sel),
        .o_wb_data   (o_wb_data),
        .o_wb_ack    (o_wb_ack),
        .o_wb_stall  (o_wb_stall),
        .o_wb_err    (o_wb_err),
        .o_mem_stb   (o_mem_stb),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_mem_sel   (o_mem_sel),
        .i_mem_data  (i_mem_data),
        .i_mem_ack   (i_mem_ack),
        .i_mem_stall (i_mem_stall)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int mem_stb_seen = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        int          at;
    } mreq_t;

    resp_t exp_resp[$];
    mreq_t exp_mem[$];
    logic [31:0] exp_rdata = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks one cycle after seeing a strobe, unless disabled.
    initial begin
        model_ack  = 1'b0;
        i_mem_data = 32'h0;
        forever begin
            @(negedge i_clk);
            if (o_mem_stb && ack_en) begin
                @(posedge i_clk);
                #1 model_ack = 1'b1;
                i_mem_data = mem_word;
                @(posedge i_clk);
                #1 model_ack = 1'b0;
            end
        end
    end

    // Upstream response monitor.
    always @(negedge i_clk) begin : mon_ack
        resp_t r;
        if (o_wb_ack) begin
            if (exp_resp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=1 err=%0b want no ack (t=%0t)", o_wb_err, $time);
            end else begin
                r = exp_resp.pop_front();
                check32("ack_data", o_wb_data, r.data);
                check32("ack_err", 32'(o_wb_err), 32'(r.err));
                check32("ack_edge", 32'(cyc), 32'(r.at));
            end
        end
    end

    // Downstream request monitor.
    always @(negedge i_clk) begin : mon_mem
        mreq_t m;
        if (o_mem_stb) begin
            mem_stb_seen++;
            if (exp_mem.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_mem_stb: got addr=%h sel=%b want no strobe", o_mem_addr, o_mem_sel);
            end else begin
                m = exp_mem.pop_front();
                check32("mem_addr", o_mem_addr, m.addr);
                check32("mem_sel", 32'(o_mem_sel), 32'(m.sel));
                check32("mem_we", 32'(o_mem_we), 32'(m.we));
                if (m.chk_data) check32("mem_data", o_mem_data, m.data);
                check32("mem_edge", 32'(cyc), 32'(m.at));
            end
        end
    end

    // Drive one request; called and returning #1 after a rising edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s, input logic mem, input logic e,
                         input logic [31:0] rd, input int ack_lat, input int mem_lat,
                         input logic [3:0] msel, input logic [31:0] mdata);
        resp_t r;
        mreq_t m;
        int acc;
        acc = cyc + 1;
        if (!e && !w) exp_rdata = rd;
        r.data = exp_rdata;
        r.err  = e;
        r.at   = acc + ack_lat;
        exp_resp.push_back(r);
        if (mem) begin
            m.addr     = a >> 2;
            m.sel      = msel;
            m.we       = w;
            m.data     = mdata;
            m.chk_data = w;
            m.at       = acc + mem_lat;
            exp_mem.push_back(m);
        end
        i_wb_stb  = 1'b1;
        i_wb_we   = w;
        i_wb_addr = a;
        i_wb_data = d;
        i_wb_sel  = s;
        @(posedge i_clk);
        #1 i_wb_stb = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && exp_resp.size() != 0; i++) @(posedge i_clk);
        if (exp_resp.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending acks want 0", name, exp_resp.size());
            exp_resp.delete();
        end
        check32({name, "_mem_pending"}, 32'(exp_mem.size()), 32'd0);
        exp_mem.delete();
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check32({tag, "_ack"},      32'(o_wb_ack),   32'd0);
        check32({tag, "_stall"},    32'(o_wb_stall), 32'd0);
        check32({tag, "_err"},      32'(o_wb_err),   32'd0);
        check32({tag, "_mem_stb"},  32'(o_mem_stb),  32'd0);
        check32({tag, "_mem_we"},   32'(o_mem_we),   32'd0);
        check32({tag, "_mem_sel"},  32'(o_mem_sel),  32'd0);
        check32({tag, "_wb_data"},  o_wb_data,       32'd0);
        check32({tag, "_mem_addr"}, o_mem_addr,      32'd0);
        check32({tag, "_mem_data"}, o_mem_data,      32'd0);
    endtask

    task automatic expect_no_ack(input string name);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check32(name, 32'(o_wb_ack), 32'd0);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic stray_pulse();
        stray_ack = 1'b1;
        @(posedge i_clk);
        #1 stray_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stb_before;
        i_reset_n   = 1'b0;
        i_wb_stb    = 1'b0;
        i_wb_we     = 1'b0;
        i_wb_addr   = 32'h0;
        i_wb_data   = 32'h0;
        i_wb_sel    = 3'b000;
        i_mem_stall = 1'b0;
        stray_ack   = 1'b0;
        ack_en      = 1'b1;
        mem_word    = 32'h0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_idle_outputs("reset");
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Word read.
        mem_word = 32'hDEADBEEF;
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 1'b0, 32'hDEADBEEF, 3, 1, 4'b1111, 32'h0);
        wait_done("word_rd");

        // Byte and halfword loads from 0x80FF0011.
        mem_word = 32'h80FF0011;
        issue(1'b0, 32'h13, 32'h0, 3'b000, 1'b1, 1'b0, 32'hFFFFFF80, 3, 1, 4'b1000, 32'h0);
        wait_done("lb_3");
        issue(1'b0, 32'h13, 32'h0, 3'b100, 1'b1, 1'b0, 32'h00000080, 3, 1, 4'b1000, 32'h0);
        wait_done("lbu_3");
        issue(1'b0, 32'h12, 32'h0, 3'b001, 1'b1, 1'b0, 32'hFFFF80FF, 3, 1, 4'b1100, 32'h0);
        wait_done("lh_2");
        issue(1'b0, 32'h12, 32'h0, 3'b101, 1'b1, 1'b0, 32'h000080FF, 3, 1, 4'b1100, 32'h0);
        wait_done("lhu_2");
        issue(1'b0, 32'h11, 32'h0, 3'b000, 1'b1, 1'b0, 32'h00000000, 3, 1, 4'b0010, 32'h0);
        wait_done("lb_1");
        issue(1'b0, 32'h10, 32'h0, 3'b001, 1'b1, 1'b0, 32'h00000011, 3, 1, 4'b0011, 32'h0);
        wait_done("lh_0");

        // Stores leave the load data register untouched.
        issue(1'b1, 32'h6, 32'h1234ABCD, 3'b001, 1'b1, 1'b0, 32'h0, 3, 1, 4'b1100, 32'hABCDABCD);
        wait_done("sh_6");
        issue(1'b1, 32'h5, 32'h000000A5, 3'b000, 1'b1, 1'b0, 32'h0, 3, 1, 4'b0010, 32'hA5A5A5A5);
        wait_done("sb_5");
        issue(1'b1, 32'h8, 32'hCAFEF00D, 3'b010, 1'b1, 1'b0, 32'h0, 3, 1, 4'b1111, 32'hCAFEF00D);
        wait_done("sw_8");

        // Illegal and misaligned requests: error ack, no memory strobe.
        stb_before = mem_stb_seen;
        issue(1'b0, 32'h2, 32'h0, 3'b010, 1'b0, 1'b1, 32'h0, 1, 0, 4'h0, 32'h0);
        wait_done("lw_mis");
        issue(1'b1, 32'h0, 32'h55, 3'b100, 1'b0, 1'b1, 32'h0, 1, 0, 4'h0, 32'h0);
        wait_done("st_bu");
        issue(1'b0, 32'h0, 32'h0, 3'b111, 1'b0, 1'b1, 32'h0, 1, 0, 4'h0, 32'h0);
        wait_done("sel_111");
        issue(1'b0, 32'h1, 32'h0, 3'b001, 1'b0, 1'b1, 32'h0, 1, 0, 4'h0, 32'h0);
        wait_done("lh_mis");
        issue(1'b0, 32'h4, 32'h0, 3'b011, 1'b0, 1'b1, 32'h0, 1, 0, 4'h0, 32'h0);
        wait_done("sel_011");
        check32("illegal_no_mem_stb", 32'(mem_stb_seen), 32'(stb_before));

        // Memory stall for 3 cycles, then no ack: error after the timeout.
        ack_en      = 1'b0;
        i_mem_stall = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b1, 1'b1, 32'h0, 8, 4, 4'b1111, 32'h0);
        repeat (3) @(posedge i_clk);
        #1 i_mem_stall = 1'b0;
        wait_done("timeout");
        stray_pulse();
        expect_no_ack("late_ack_idle");

        // Reset in the middle of a wait abandons the transaction.
        issue(1'b0, 32'h30, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0, 3, 1, 4'b1111, 32'h0);
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1 i_reset_n = 1'b0;
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        exp_resp.delete();
        exp_rdata = 32'h0;
        @(negedge i_clk);
        check_idle_outputs("mid_rst");
        check32("mid_rst_mem_pending", 32'(exp_mem.size()), 32'd0);
        exp_mem.delete();
        @(posedge i_clk);
        #1;
        stray_pulse();
        expect_no_ack("post_rst_ack");

        ack_en   = 1'b1;
        mem_word = 32'h00007F00;
        issue(1'b0, 32'h31, 32'h0, 3'b000, 1'b1, 1'b0, 32'h0000007F, 3, 1, 4'b0010, 32'h0);
        wait_done("post_rst_lb");

        repeat (2) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
